// File: rtl/ddr_init_sequencer.sv
// DDR1 power-up initialisation sequencer.
// Walks CKE and the command bus through the JEDEC init sequence, then raises init_done.
module ddr_init_sequencer #(
    parameter int                    ADDR_WIDTH     = 13,
    parameter int                    STARTUP_CYCLES = 20000,
    parameter int                    T_CKE          = 2,
    parameter int                    T_RP           = 3,
    parameter int                    T_MRD          = 2,
    parameter int                    T_RFC          = 8,
    parameter int                    T_DLL          = 200,
    parameter logic [ADDR_WIDTH-1:0] MODE_REG       = 13'h0022,
    parameter logic [ADDR_WIDTH-1:0] EMODE_REG      = 13'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_ok,
    output logic                  cke,
    output logic [3:0]            cmd,
    output logic [1:0]            ba,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  init_done
);

    typedef enum logic [3:0] {
        S_WAIT_LOCK,
        S_STARTUP,
        S_CKE_UP,
        S_PRE1,
        S_EMRS,
        S_MRS_DLLRST,
        S_PRE2,
        S_REF1,
        S_REF2,
        S_MRS,
        S_DONE
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // Counter reload values: a wait of T cycles counts T-1 down to 0.
    localparam logic [19:0] CNT_STARTUP = 20'(STARTUP_CYCLES - 1);
    localparam logic [19:0] CNT_CKE     = 20'(T_CKE - 1);
    localparam logic [19:0] CNT_RP      = 20'(T_RP - 1);
    localparam logic [19:0] CNT_MRD     = 20'(T_MRD - 1);
    localparam logic [19:0] CNT_RFC     = 20'(T_RFC - 1);
    localparam logic [19:0] CNT_DLL     = 20'(T_DLL - 1);

    localparam logic [ADDR_WIDTH-1:0] DLL_RST_BIT =
        {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << 8;

    state_t            state;
    state_t            state_nx;
    logic [19:0]       cnt;
    logic [19:0]       cnt_nx;
    logic              cke_nx;
    logic [3:0]        cmd_nx;
    logic [1:0]        ba_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic              done_nx;

    // State, shared wait counter and registered pin outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            cke       <= 1'b0;
            cmd       <= CMD_NOP;
            ba        <= 2'b00;
            addr      <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cke       <= cke_nx;
            cmd       <= cmd_nx;
            ba        <= ba_nx;
            addr      <= addr_nx;
            init_done <= done_nx;
        end
    end

    // Next state: lock loss aborts, otherwise advance when the wait expires.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state != S_DONE && !clk_ok) begin
            state_nx = S_WAIT_LOCK;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                S_WAIT_LOCK: begin
                    state_nx = S_STARTUP;
                    cnt_nx   = CNT_STARTUP;
                end
                S_DONE: begin
                    state_nx = S_DONE;
                end
                default: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - 20'd1;
                    end else begin
                        unique case (state)
                            S_STARTUP: begin
                                state_nx = S_CKE_UP;
                                cnt_nx   = CNT_CKE;
                            end
                            S_CKE_UP: begin
                                state_nx = S_PRE1;
                                cnt_nx   = CNT_RP;
                            end
                            S_PRE1: begin
                                state_nx = S_EMRS;
                                cnt_nx   = CNT_MRD;
                            end
                            S_EMRS: begin
                                state_nx = S_MRS_DLLRST;
                                cnt_nx   = CNT_MRD;
                            end
                            S_MRS_DLLRST: begin
                                state_nx = S_PRE2;
                                cnt_nx   = CNT_RP;
                            end
                            S_PRE2: begin
                                state_nx = S_REF1;
                                cnt_nx   = CNT_RFC;
                            end
                            S_REF1: begin
                                state_nx = S_REF2;
                                cnt_nx   = CNT_RFC;
                            end
                            S_REF2: begin
                                state_nx = S_MRS;
                                cnt_nx   = CNT_DLL;
                            end
                            S_MRS: begin
                                state_nx = S_DONE;
                                cnt_nx   = '0;
                            end
                            default: begin
                                state_nx = S_WAIT_LOCK;
                                cnt_nx   = '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Outputs for the coming cycle: a command only on entry to its state.
    always_comb begin
        cke_nx  = (state_nx != S_WAIT_LOCK) && (state_nx != S_STARTUP);
        cmd_nx  = CMD_NOP;
        ba_nx   = 2'b00;
        addr_nx = '0;
        done_nx = (state_nx == S_DONE);
        if (state_nx != state) begin
            unique case (state_nx)
                S_PRE1, S_PRE2: begin
                    cmd_nx      = CMD_PRE;
                    addr_nx[10] = 1'b1;
                end
                S_EMRS: begin
                    cmd_nx  = CMD_LMR;
                    ba_nx   = 2'b01;
                    addr_nx = EMODE_REG;
                end
                S_MRS_DLLRST: begin
                    cmd_nx  = CMD_LMR;
                    addr_nx = MODE_REG | DLL_RST_BIT;
                end
                S_REF1, S_REF2: begin
                    cmd_nx = CMD_REF;
                end
                S_MRS: begin
                    cmd_nx  = CMD_LMR;
                    addr_nx = MODE_REG & ~DLL_RST_BIT;
                end
                default: begin
                    cmd_nx = CMD_NOP;
                end
            endcase
        end
    end

endmodule

// File: doc/ddr_init_sequencer.md
Name: ddr_init_sequencer

Overview:
- Power-up initialisation sequencer for the DDR SDRAM. Runs in the DDR controller clock domain (ddr_clk_0).
- Consumes the DDR clock lock indication and drives CKE and the command, bank and address pins through the JEDEC DDR1 init sequence.
- Raises init_done when the device is ready. The DDR controller takes over the command bus only after init_done.

Parameters:
- ADDR_WIDTH, 13, width of the SDRAM address bus.
- STARTUP_CYCLES, 20000, CKE-low stable-clock wait (200 us at 100 MHz); legal range 1 to 2^20-1.
- T_CKE, 2, cycles from CKE rise to the first PRECHARGE; minimum 1.
- T_RP, 3, cycles from PRECHARGE to the next command; minimum 1.
- T_MRD, 2, cycles from a mode-register load to the next command; minimum 1.
- T_RFC, 8, cycles from AUTO REFRESH to the next command; minimum 1.
- T_DLL, 200, cycles from the final LOAD MODE to init_done; minimum 1.
- MODE_REG, 13'h0022, normal mode-register value: CAS 2, burst length 4, sequential.
- EMODE_REG, 13'h0000, extended mode-register value: DLL enabled, normal drive.

Ports:
- clk  in  1  DDR controller clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low; logic is reset while reset==0.
- clk_ok  in  1  DDR clock lock indication; level, synchronous to clk.
- cke  out  1  SDRAM clock enable.
- cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- ba  out  2  bank address.
- addr  out  ADDR_WIDTH  SDRAM address.
- init_done  out  1  high once the sequence has completed.

Behaviour:
- Outputs:
  - All outputs are registered.
  - Reset values: cke=0, cmd=NOP (4'b0111), ba=0, addr=0, init_done=0.
- Command encodings:
  - NOP 0111.
  - PRECHARGE 0010, with addr[10]=1 (precharge all).
  - AUTO REFRESH 0001.
  - LOAD MODE 0000.
  - Between commands the outputs hold cmd=NOP, ba=0, addr=0.
- Implementation: one down-counter, 20 bits, shared by all waits, plus a state register.
- Command spacing: each command is driven for exactly one cycle. If a command appears in cycle N with wait T, the next command or event appears in cycle N+T.
- States, in order:
  1. WAIT_LOCK: cke=0; stay until clk_ok=1.
  2. STARTUP: cke=0 for STARTUP_CYCLES cycles, counted from the first cycle clk_ok is sampled high.
  3. CKE_UP: cke=1, then T_CKE NOP cycles.
  4. PRE1: PRECHARGE all; wait T_RP.
  5. EMRS: LOAD MODE, ba=01, addr=EMODE_REG; wait T_MRD.
  6. MRS_DLLRST: LOAD MODE, ba=00, addr=MODE_REG with bit 8 set (DLL reset); wait T_MRD.
  7. PRE2: PRECHARGE all; wait T_RP.
  8. REF1: AUTO REFRESH; wait T_RFC.
  9. REF2: AUTO REFRESH; wait T_RFC.
  10. MRS: LOAD MODE, ba=00, addr=MODE_REG with bit 8 cleared; wait T_DLL.
  11. DONE: init_done=1 (sticky), cke=1, cmd=NOP.
- In DONE the block never issues another command.
- Loss of lock:
  - clk_ok=0 in any state other than DONE: on the next edge go to WAIT_LOCK with cke=0, cmd=NOP and the counter cleared. The full sequence restarts when lock returns.
  - clk_ok=0 in DONE: no effect; the system reset handles that case.
- Reset mid-sequence: asynchronous return to WAIT_LOCK with the reset values above.

Test Plan (STARTUP_CYCLES=10, defaults otherwise):
- Reset low, clk_ok=1 -> cke=0, cmd=0111, init_done=0 throughout reset.
- Release reset, clk_ok=1 from cycle 0 -> cke rises at cycle 10; first PRECHARGE (0010, addr[10]=1) at cycle 12.
- Full sequence -> command cycles are PRE 12, EMRS 15 (ba=01, addr=0x000), MRS 17 (ba=00, addr=0x122), PRE 19, REF 22, REF 30, MRS 38 (addr=0x022); init_done rises at cycle 238; NOP in every other cycle.
- Drop clk_ok for one cycle at cycle 20 (during PRE2 wait) -> cke=0 next cycle, no further commands. Restore clk_ok -> sequence restarts, with cke rising 10 cycles after re-lock.
- Drop clk_ok after init_done=1 -> init_done stays 1, cke stays 1, cmd stays NOP.
- Assert reset asynchronously mid-REF wait -> outputs go to reset values immediately, without waiting for a clk edge.
